trap_ctrl: RTL
==============

Name: trap_ctrl

Overview:
- Exception front end that sits directly upstream of the CSR file.
- Collects synchronous exception flags and MRET from the execute stage, prioritises them, and issues a one-cycle trap request (trap, trap_cause, trap_value, trap_pc) to the CSR file.
- Waits for trap_handled, then redirects fetch to trap_target_pc with a pipeline flush.
- Handles MRET by redirecting to mepc.

Parameters:
- ACK_TIMEOUT, 16, maximum cycles in WAIT_ACK before abandoning the trap.
- RESET_VECTOR, 32'h0000_0000, redirect target used after a timeout.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high (asserted when rst_n=1)
- ex_valid  in  1  execute-stage instruction valid
- ex_pc  in  32  execute-stage PC
- ex_instr  in  32  execute-stage instruction word
- ex_target  in  32  computed branch/jump target
- ex_mem_addr  in  32  computed load/store address
- exc_illegal  in  1  illegal instruction
- exc_iaddr_misaligned  in  1  misaligned branch/jump target
- exc_ecall  in  1  ECALL
- exc_ebreak  in  1  EBREAK
- exc_load_misaligned  in  1  misaligned load
- exc_store_misaligned  in  1  misaligned store
- mret  in  1  MRET in execute
- mepc  in  32  current MEPC from the CSR file
- trap  out  1  trap request to the CSR file
- trap_cause  out  4  cause code
- trap_value  out  32  MTVAL value
- trap_pc  out  32  faulting PC
- trap_handled  in  1  CSR file acknowledge
- trap_target_pc  in  32  handler address from the CSR file
- stall  out  1  hold upstream stages
- flush  out  1  kill younger instructions
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  fetch redirect target
- trap_timeout  out  1  sticky, acknowledge never arrived

Behaviour:
- Reset (rst_n=1, asynchronous):
  - State goes to IDLE.
  - All registered outputs, including trap_timeout, are 0; the watchdog counter is 0.
  - Reset mid-operation abandons any trap in flight with no redirect.
- States: IDLE, RAISE, WAIT_ACK, REDIRECT.
- any_exc = ex_valid & OR(exc_*).
- Priority, high to low:
  - illegal: value=ex_instr
  - iaddr_misaligned: value=ex_target
  - ecall: value=0
  - ebreak: value=ex_pc
  - load_misaligned: value=ex_mem_addr
  - store_misaligned: value=ex_mem_addr
- IDLE:
  - If any_exc: latch the winning cause and value, latch trap_pc=ex_pc, go to RAISE.
  - Else if ex_valid & mret: latch redirect_pc={mepc[31:2],2'b00}, go to REDIRECT.
  - An exception beats MRET in the same cycle; the MRET is dropped.
  - Flags with ex_valid=0 are ignored.
- RAISE (exactly one cycle):
  - trap=1 and flush=1.
  - Cause, value and pc are stable from RAISE through WAIT_ACK.
  - If trap_handled=1 in this cycle, latch trap_target_pc and go to REDIRECT; else go to WAIT_ACK.
- WAIT_ACK:
  - trap=0; the counter increments each cycle.
  - On trap_handled: latch trap_target_pc, go to REDIRECT.
  - When the counter reaches ACK_TIMEOUT-1 with no acknowledge: set trap_timeout, set redirect_pc=RESET_VECTOR, go to REDIRECT.
  - If acknowledge and timeout occur in the same cycle, the acknowledge wins.
- REDIRECT (one cycle):
  - redirect_valid=1.
  - flush=1 for the MRET path only; the trap path has already flushed in RAISE.
  - Next state is IDLE; the counter clears.
- stall is combinational: (state!=IDLE) | any_exc | (ex_valid & mret). Upstream holds the instruction; new exc_* inputs are ignored while not IDLE.
- Latencies:
  - Exception to trap: 1 cycle.
  - Minimum exception to redirect: 2 cycles (acknowledge in RAISE).
  - MRET to redirect: 1 cycle.
- trap_cause and trap_value are 0 in IDLE and REDIRECT.

Decomposition:
- Shared core package holds:
  - the trap-cause constants (TRAP_ILLEGAL, TRAP_IADDR_MISALIGNED, TRAP_ECALL_M, TRAP_BREAKPOINT, TRAP_LOAD_MISALIGNED, TRAP_STORE_MISALIGNED), the same encodings the CSR file uses;
  - the trap_ctrl_state_t enum.
- One sub-module, trap_prio_enc: combinational priority encoder from the exc_* vector to {valid, cause, value_sel}.
- The FSM and watchdog stay in trap_ctrl.

Test Plan:
- Illegal instruction:
  - Stimulus: ex_valid=1, exc_illegal=1, ex_pc=0x20, ex_instr=0xFFFFFFFF; CSR model acknowledges 1 cycle after trap with trap_target_pc=0x10.
  - Required: trap pulse of 1 cycle with cause=TRAP_ILLEGAL, value=0xFFFFFFFF, pc=0x20; flush in RAISE; redirect_valid with redirect_pc=0x10 one cycle after the acknowledge.
- Priority:
  - Stimulus: exc_illegal, exc_ecall and exc_load_misaligned all asserted, ex_mem_addr=0x1003.
  - Required: cause=TRAP_ILLEGAL and value=ex_instr. Repeat with only ecall and load_misaligned: cause=TRAP_ECALL_M, value=0.
- MRET:
  - Stimulus: mret=1, mepc=0x00000123, no exceptions.
  - Required: next cycle redirect_valid=1, redirect_pc=0x00000120, flush=1; trap never asserted. Repeat with exc_ecall also set: the trap is taken and MRET is ignored.
- Timeout:
  - Stimulus: trap_handled never asserted.
  - Required: after ACK_TIMEOUT cycles, trap_timeout=1 (sticky), redirect_pc=RESET_VECTOR, return to IDLE.
- Stall and busy:
  - Stimulus: new exc_store_misaligned asserted while in WAIT_ACK.
  - Required: no second trap; stall=1 throughout until the REDIRECT cycle ends.
- Reset mid-trap:
  - Stimulus: assert rst_n during WAIT_ACK.
  - Required: trap, flush, redirect_valid and trap_timeout are 0 immediately, state is IDLE, and no redirect is issued after release.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared core definitions for the exception front end:
//   - trap-cause encodings, identical to the ones the CSR file decodes
//   - trap_ctrl FSM state type
//   - exception flag bundle and MTVAL source selector
//   - align_word(): clears the low two bits of an address
// -----------------------------------------------------------------------------
package trap_ctrl_pkg;

  localparam logic [3:0] TRAP_IADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] TRAP_ILLEGAL          = 4'd2;
  localparam logic [3:0] TRAP_BREAKPOINT       = 4'd3;
  localparam logic [3:0] TRAP_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] TRAP_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] TRAP_ECALL_M          = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAISE,
    ST_WAIT_ACK,
    ST_REDIRECT
  } trap_ctrl_state_t;

  // Which execute-stage quantity becomes MTVAL for the winning exception.
  typedef enum logic [2:0] {
    VSEL_ZERO,
    VSEL_INSTR,
    VSEL_TARGET,
    VSEL_PC,
    VSEL_MEM_ADDR
  } value_sel_t;

  typedef struct packed {
    logic store_misaligned;
    logic load_misaligned;
    logic ebreak;
    logic ecall;
    logic iaddr_misaligned;
    logic illegal;
  } exc_flags_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// -----------------------------------------------------------------------------
// trap_ctrl_if
// Bundles everything trap_ctrl exchanges with the pipeline and the CSR file.
//   slave  : the trap_ctrl side (consumes execute/CSR inputs, drives trap,
//            stall/flush and the fetch redirect)
//   master : the environment side (execute stage, CSR file, fetch)
// -----------------------------------------------------------------------------
interface trap_ctrl_if;

  // Execute stage
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_instr;
  logic [31:0] ex_target;
  logic [31:0] ex_mem_addr;
  logic        exc_illegal;
  logic        exc_iaddr_misaligned;
  logic        exc_ecall;
  logic        exc_ebreak;
  logic        exc_load_misaligned;
  logic        exc_store_misaligned;
  logic        mret;

  // CSR file
  logic [31:0] mepc;
  logic        trap;
  logic [3:0]  trap_cause;
  logic [31:0] trap_value;
  logic [31:0] trap_pc;
  logic        trap_handled;
  logic [31:0] trap_target_pc;

  // Pipeline control / fetch
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_timeout;

  modport slave (
    input  ex_valid, ex_pc, ex_instr, ex_target, ex_mem_addr,
    input  exc_illegal, exc_iaddr_misaligned, exc_ecall, exc_ebreak,
    input  exc_load_misaligned, exc_store_misaligned, mret,
    input  mepc, trap_handled, trap_target_pc,
    output trap, trap_cause, trap_value, trap_pc,
    output stall, flush, redirect_valid, redirect_pc, trap_timeout
  );

  modport master (
    output ex_valid, ex_pc, ex_instr, ex_target, ex_mem_addr,
    output exc_illegal, exc_iaddr_misaligned, exc_ecall, exc_ebreak,
    output exc_load_misaligned, exc_store_misaligned, mret,
    output mepc, trap_handled, trap_target_pc,
    input  trap, trap_cause, trap_value, trap_pc,
    input  stall, flush, redirect_valid, redirect_pc, trap_timeout
  );

endinterface

// File: rtl/trap_prio_enc.sv
// -----------------------------------------------------------------------------
// trap_prio_enc
// Combinational priority encoder for synchronous exceptions.
//   flags     in  : raw exception flags from execute
//   valid     out : at least one flag set
//   cause     out : cause code of the highest-priority flag
//   value_sel out : which execute quantity supplies MTVAL
// Priority (high to low): illegal, iaddr_misaligned, ecall, ebreak,
// load_misaligned, store_misaligned.
// -----------------------------------------------------------------------------
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  exc_flags_t flags,
  output logic       valid,
  output logic [3:0] cause,
  output value_sel_t value_sel
);

  always_comb begin
    // NOTE: every output gets a default before the if-chain so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    valid     = 1'b1;
    cause     = '0;
    value_sel = VSEL_ZERO;
    if (flags.illegal) begin
      cause     = TRAP_ILLEGAL;
      value_sel = VSEL_INSTR;
    end else if (flags.iaddr_misaligned) begin
      cause     = TRAP_IADDR_MISALIGNED;
      value_sel = VSEL_TARGET;
    end else if (flags.ecall) begin
      cause     = TRAP_ECALL_M;
      value_sel = VSEL_ZERO;
    end else if (flags.ebreak) begin
      cause     = TRAP_BREAKPOINT;
      value_sel = VSEL_PC;
    end else if (flags.load_misaligned) begin
      cause     = TRAP_LOAD_MISALIGNED;
      value_sel = VSEL_MEM_ADDR;
    end else if (flags.store_misaligned) begin
      cause     = TRAP_STORE_MISALIGNED;
      value_sel = VSEL_MEM_ADDR;
    end else begin
      valid     = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
// Exception front end directly upstream of the CSR file. Prioritises the
// execute-stage exception flags, raises a one-cycle trap request, waits for
// the CSR acknowledge (with a watchdog) and redirects fetch to the handler.
// MRET redirects fetch to MEPC.
//   clk    in : clock
//   rst_n  in : asynchronous reset, asserted HIGH (legacy polarity of this
//               codebase despite the name)
//   bus       : trap_ctrl_if.slave -- execute inputs, CSR handshake,
//               stall/flush and fetch redirect outputs
// Parameters:
//   ACK_TIMEOUT  : cycles spent in WAIT_ACK before the trap is abandoned
//   RESET_VECTOR : redirect target after an abandoned trap
// -----------------------------------------------------------------------------
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT  = 16,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic        clk,
  input logic        rst_n,
  trap_ctrl_if.slave bus
);

  localparam int unsigned    CNT_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  trap_ctrl_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic             flush_q, flush_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic [3:0]       trap_cause_q, trap_cause_d;
  logic [31:0]      trap_value_q, trap_value_d;
  logic [31:0]      trap_pc_q, trap_pc_d;
  logic             trap_timeout_q, trap_timeout_d;

  exc_flags_t  exc_flags;
  logic        enc_valid;
  logic [3:0]  enc_cause;
  value_sel_t  enc_value_sel;
  logic [31:0] exc_value;
  logic        any_exc;
  logic        mret_req;

  assign exc_flags = '{
    store_misaligned: bus.exc_store_misaligned,
    load_misaligned:  bus.exc_load_misaligned,
    ebreak:           bus.exc_ebreak,
    ecall:            bus.exc_ecall,
    iaddr_misaligned: bus.exc_iaddr_misaligned,
    illegal:          bus.exc_illegal
  };

  trap_prio_enc u_prio_enc (
    .flags     (exc_flags),
    .valid     (enc_valid),
    .cause     (enc_cause),
    .value_sel (enc_value_sel)
  );

  assign any_exc  = bus.ex_valid & enc_valid;
  assign mret_req = bus.ex_valid & bus.mret;

  always_comb begin
    exc_value = '0;
    case (enc_value_sel)
      VSEL_INSTR:    exc_value = bus.ex_instr;
      VSEL_TARGET:   exc_value = bus.ex_target;
      VSEL_PC:       exc_value = bus.ex_pc;
      VSEL_MEM_ADDR: exc_value = bus.ex_mem_addr;
      default:       exc_value = '0;
    endcase
  end

  // Next-state and next-output logic. Strobes (trap, flush, redirect_valid)
  // default low so each is a single-cycle pulse; cause/value are cleared on
  // every entry into REDIRECT so they read 0 outside RAISE/WAIT_ACK.
  always_comb begin
    state_d          = state_q;
    cnt_d            = '0;
    trap_d           = 1'b0;
    flush_d          = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    trap_cause_d     = trap_cause_q;
    trap_value_d     = trap_value_q;
    trap_pc_d        = trap_pc_q;
    trap_timeout_d   = trap_timeout_q;

    case (state_q)
      ST_IDLE: begin
        trap_cause_d = '0;
        trap_value_d = '0;
        // An exception wins over a simultaneous MRET; the MRET is dropped.
        if (any_exc) begin
          state_d      = ST_RAISE;
          trap_d       = 1'b1;
          flush_d      = 1'b1;
          trap_cause_d = enc_cause;
          trap_value_d = exc_value;
          trap_pc_d    = bus.ex_pc;
        end else if (mret_req) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          redirect_pc_d    = align_word(bus.mepc);
        end
      end

      ST_RAISE: begin
        if (bus.trap_handled) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = bus.trap_target_pc;
          trap_cause_d     = '0;
          trap_value_d     = '0;
        end else begin
          state_d = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        // Acknowledge is tested first so it wins over a coincident timeout.
        if (bus.trap_handled) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = bus.trap_target_pc;
          trap_cause_d     = '0;
          trap_value_d     = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d          = ST_REDIRECT;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = RESET_VECTOR;
          trap_timeout_d   = 1'b1;
          trap_cause_d     = '0;
          trap_value_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      trap_q           <= 1'b0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      trap_cause_q     <= '0;
      trap_value_q     <= '0;
      trap_pc_q        <= '0;
      trap_timeout_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed for this edge, independent of statement order.
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      trap_q           <= trap_d;
      flush_q          <= flush_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      trap_cause_q     <= trap_cause_d;
      trap_value_q     <= trap_value_d;
      trap_pc_q        <= trap_pc_d;
      trap_timeout_q   <= trap_timeout_d;
    end
  end

  // stall is combinational so upstream freezes in the same cycle the
  // exception or MRET is presented.
  assign bus.stall          = (state_q != ST_IDLE) | any_exc | mret_req;
  assign bus.trap           = trap_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.trap_cause     = trap_cause_q;
  assign bus.trap_value     = trap_value_q;
  assign bus.trap_pc        = trap_pc_q;
  assign bus.trap_timeout   = trap_timeout_q;

endmodule
